// File: rtl/muldiv_unit.sv
// Iterative signed multiply/divide: radix-2 Booth multiplier and restoring divider
// sharing one counter, one working register pair and one FSM. Results land on hi/lo.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StMult, StDiv, StFinish} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, quo_q, quo_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             xbit_q, xbit_d, op_q, op_d, dz_q, dz_d;
  logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic             done_q, done_d, div_zero_q, div_zero_d;
  logic             accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   booth_sum, rem_shift, rem_trial;

  assign accept = start && (state_q == StIdle || state_q == StFinish);
  assign a_mag  = a[WIDTH-1] ? -a : a;
  assign b_mag  = b[WIDTH-1] ? -b : b;

  // Booth step on a sign-extended accumulator so subtracting -2^(W-1) cannot overflow.
  always_comb begin
    case ({quo_q[0], xbit_q})
      2'b01:   booth_sum = {acc_q[WIDTH-1], acc_q} + {opnd_q[WIDTH-1], opnd_q};
      2'b10:   booth_sum = {acc_q[WIDTH-1], acc_q} - {opnd_q[WIDTH-1], opnd_q};
      default: booth_sum = {acc_q[WIDTH-1], acc_q};
    endcase
  end

  assign rem_shift = {acc_q, quo_q[WIDTH-1]};
  assign rem_trial = rem_shift - {1'b0, opnd_q};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StFinish: begin
        if (start) begin
          if (!op)           state_d = StMult;
          else if (b == '0)  state_d = StFinish;
          else               state_d = StDiv;
        end else begin
          state_d = StIdle;
        end
      end
      StMult, StDiv: if (cnt_q == CntW'(1)) state_d = StFinish;
      default:       state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    quo_d      = quo_q;
    xbit_d     = xbit_q;
    opnd_d     = opnd_q;
    op_d       = op_q;
    dz_d       = dz_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
    done_d     = (state_q == StFinish);

    if (accept) begin
      op_d       = op;
      dz_d       = op && (b == '0);
      neg_quo_d  = a[WIDTH-1] ^ b[WIDTH-1];
      neg_rem_d  = a[WIDTH-1];
      cnt_d      = CntW'(WIDTH);
      acc_d      = '0;
      xbit_d     = 1'b0;
      quo_d      = op ? a_mag : b;
      opnd_d     = op ? b_mag : a;
      div_zero_d = 1'b0;
    end else if (state_q == StMult) begin
      acc_d  = booth_sum[WIDTH:1];
      quo_d  = {booth_sum[0], quo_q[WIDTH-1:1]};
      xbit_d = quo_q[0];
      cnt_d  = cnt_q - CntW'(1);
    end else if (state_q == StDiv) begin
      if (!rem_trial[WIDTH]) begin
        acc_d = rem_trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = rem_shift[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q - CntW'(1);
    end

    // Result write-back; a div-by-zero flag being reported wins over a same-edge clear.
    if (state_q == StFinish) begin
      if (dz_q) begin
        div_zero_d = 1'b1;
      end else if (op_q) begin
        lo_d = neg_quo_q ? -quo_q : quo_q;
        hi_d = neg_rem_q ? -acc_q : acc_q;
      end else begin
        hi_d = acc_q;
        lo_d = quo_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      quo_q      <= '0;
      xbit_q     <= 1'b0;
      opnd_q     <= '0;
      op_q       <= 1'b0;
      dz_q       <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      quo_q      <= quo_d;
      xbit_q     <= xbit_d;
      opnd_q     <= opnd_d;
      op_q       <= op_d;
      dz_q       <= dz_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = (state_q == StMult) || (state_q == StDiv);
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule
